// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 16-bit ALU: decodes, reads RF, captures the result, writes back, holds PSR.
// Optional ALU_ILLEGAL_TRAP_EN: illegal decode sets a sticky flag and halts until reset.
module alu_issue_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4,
    parameter int unsigned FW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [AW-1:0] rf_raddr_a,
    output logic [AW-1:0] rf_raddr_b,
    input  logic [DW-1:0] rf_rdata_a,
    input  logic [DW-1:0] rf_rdata_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [7:0]    alu_opcode,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_c,
    input  logic [FW-1:0] alu_flags,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [FW-1:0] psr_flags,
    output logic          busy,
    output logic          illegal
);
    localparam int unsigned IW      = 16;
    localparam int unsigned OW      = 8;
    localparam int unsigned CIN_BIT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic          legal;
        logic          wr;
        logic          upd;
        logic          imm;
        logic [OW-1:0] opc;
    } dec_t;

    // Instruction decode: legality, write-back/PSR effects, operand B source, ALU opcode.
    function automatic dec_t decode(input logic [IW-1:0] w);
        dec_t d;
        d = '0;
        case (w[15:12])
            4'h0: begin
                d.opc = {4'h0, w[7:4]};
                case (w[7:4])
                    4'h0:       d.legal = 1'b1;
                    4'hB, 4'hF: begin d.legal = 1'b1; d.upd = 1'b1; end
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hD: begin
                        d.legal = 1'b1; d.wr = 1'b1; d.upd = 1'b1;
                    end
                    default:    d.legal = 1'b0;
                endcase
            end
            4'h5, 4'h6, 4'h7: begin
                d.opc   = {w[15:12], 4'h0};
                d.legal = 1'b1; d.wr = 1'b1; d.upd = 1'b1; d.imm = 1'b1;
            end
            4'h8: begin
                d.opc = {4'h8, w[7:4]};
                case (w[7:4])
                    4'h0, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB: begin
                        d.legal = 1'b1; d.wr = 1'b1; d.upd = 1'b1;
                    end
                    default: d.legal = 1'b0;
                endcase
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic is_legal(input logic [IW-1:0] w);
        dec_t d;
        d = decode(w);
        return d.legal;
    endfunction

    state_t        state, state_d;
    logic [IW-1:0] instr_q;
    logic [FW-1:0] flg_q;
    dec_t          dec_q;
    logic          instr_legal_c;
    logic          accept_c;

    assign dec_q         = decode(instr_q);
    assign instr_legal_c = is_legal(instr);
    assign accept_c      = (state == S_IDLE) && instr_valid;
    assign rf_raddr_a    = AW'(instr_q[11:8]);
    assign rf_raddr_b    = AW'(instr_q[3:0]);

    // Next state and ALU drive; ALU inputs are only live during EXEC.
    always_comb begin
        state_d    = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        alu_cin    = 1'b0;
        case (state)
            S_IDLE: if (instr_valid) state_d = S_READ;
            S_READ: begin
`ifdef ALU_ILLEGAL_TRAP_EN
                if (!dec_q.legal) state_d = S_HALT;
                else              state_d = S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                state_d    = S_WB;
                alu_a      = rf_rdata_a;
                alu_b      = dec_q.imm ? DW'(instr_q[7:0]) : rf_rdata_b;
                alu_opcode = dec_q.legal ? dec_q.opc : '0;
                alu_cin    = psr_flags[CIN_BIT];
            end
            S_WB:    state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            flg_q       <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            psr_flags   <= '0;
            illegal     <= 1'b0;
        end else begin
            state       <= state_d;
            instr_ready <= (state_d == S_IDLE);
            busy        <= (state_d != S_IDLE);
            rf_we       <= (state == S_EXEC) && dec_q.wr;
            if (accept_c) instr_q <= instr;
            // rf_wdata doubles as the captured ALU result for WB
            if (state == S_EXEC) begin
                rf_wdata <= alu_c;
                flg_q    <= alu_flags;
                rf_waddr <= AW'(instr_q[11:8]);
            end
            if ((state == S_WB) && dec_q.upd) psr_flags <= flg_q;
`ifdef ALU_ILLEGAL_TRAP_EN
            if (accept_c && !instr_legal_c) illegal <= 1'b1;
`else
            illegal <= accept_c && !instr_legal_c;
`endif
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stand-in RF and ALU, reference model predicts each instruction.
// Honours ALU_ILLEGAL_TRAP_EN the same way as the design.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid, instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_c, rf_wdata;
    logic [7:0]  alu_opcode;
    logic        alu_cin, rf_we, busy, illegal;
    logic [4:0]  alu_flags, psr_flags;

    logic        pl_we;
    logic [3:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] rf [16];

    typedef struct {
        logic [15:0] w;
        bit          legal, wr, upd;
        logic [7:0]  opc;
        logic [3:0]  rd, rs;
        logic [15:0] a, b, c;
        logic        cin;
        logic [4:0]  psr_after;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [15:0] mrf [16];
    logic [4:0]  mpsr;
    int          checks = 0;
    int          errors = 0;
    int          ph = 0;
    int          we_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_c(alu_c), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .psr_flags(psr_flags),
        .busy(busy), .illegal(illegal)
    );

    // Stand-in ALU; flags packed {Z,C,F,N,L}
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic        cf, vf, nf, lf;
        cf = 1'b0; vf = 1'b0; nf = 1'b0; lf = 1'b0;
        case (op)
            8'h05, 8'h06, 8'h50, 8'h60: s = {1'b0, a} + {1'b0, b};
            8'h07, 8'h70:               s = {1'b0, a} + {1'b0, b} + 17'(cin);
            8'h09, 8'h0B, 8'h0F:        s = {1'b0, a} - {1'b0, b};
            default:                    s = {1'b0, a ^ (b + 16'(op))};
        endcase
        c = s[15:0];
        if (op inside {8'h05, 8'h06, 8'h07, 8'h50, 8'h60, 8'h70}) begin
            cf = s[16];
            vf = (a[15] == b[15]) && (c[15] != a[15]);
            nf = c[15];
        end else if (op inside {8'h0B, 8'h0F}) begin
            lf = a < b;
            nf = $signed(a) < $signed(b);
        end else begin
            nf = c[15];
        end
        return {c, (c == 16'h0000), cf, vf, nf, lf};
    endfunction

    assign {alu_c, alu_flags} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

    // Synchronous-read register file with a backdoor preload port
    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (pl_we) rf[pl_addr] <= pl_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what one instruction should do given the architectural state
    function automatic exp_t predict(input logic [15:0] w);
        exp_t        e;
        logic [3:0]  oh, ex;
        logic [20:0] r;
        oh = w[15:12]; ex = w[7:4];
        e.w = w; e.rd = w[11:8]; e.rs = w[3:0];
        e.legal = 0; e.wr = 0; e.upd = 0; e.opc = 8'h00;
        e.a = mrf[w[11:8]]; e.b = mrf[w[3:0]]; e.cin = mpsr[3];
        if (oh == 4'h0) begin
            e.opc   = {4'h0, ex};
            e.legal = ex inside {[4'h0:4'h9], 4'hB, 4'hD, 4'hF};
            e.upd   = e.legal && (ex != 4'h0);
            e.wr    = e.upd && !(ex inside {4'hB, 4'hF});
        end else if (oh inside {4'h5, 4'h6, 4'h7}) begin
            e.opc = {oh, 4'h0};
            e.b   = {8'h00, w[7:0]};
            e.legal = 1; e.wr = 1; e.upd = 1;
        end else if (oh == 4'h8) begin
            e.opc   = {4'h8, ex};
            e.legal = ex inside {4'h0, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
            e.wr    = e.legal;
            e.upd   = e.legal;
        end
        r = alu_fn(e.opc, e.a, e.b, e.cin);
        e.c = r[20:5];
        e.psr_after = e.upd ? r[4:0] : mpsr;
        return e;
    endfunction

    function automatic logic [15:0] gen();
        logic [15:0] w;
        case ($urandom_range(0, 4))
            0:       w = {4'h0, 12'($urandom)};
            1:       w = {4'(5 + $urandom_range(0, 2)), 12'($urandom)};
            2:       w = {4'h8, 12'($urandom)};
            3:       w = 16'($urandom);
            default: w = {4'h0, 4'($urandom), 4'h7, 4'($urandom)};
        endcase
        return w;
    endfunction

    task automatic issue(input logic [15:0] w, input bit commit);
        exp_t e;
        bit   done;
        e = predict(w);
        if (commit) begin
            if (e.wr) mrf[e.rd] = e.c;
            mpsr = e.psr_after;
        end
        q.push_back(e);
        @(posedge clk); #1;
        instr = w; instr_valid = 1'b1; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                @(posedge clk); #1;
                instr_valid = 1'b0; instr = 16'($urandom); done = 1;
            end
        end
        if (!done) begin
            chk("accept_timeout", 32'(0), 32'(1));
            instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (instr_ready) done = 1;
        end
        if (!done) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d; mrf[a] = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Monitor: follows each accepted instruction through READ/EXEC/WB and checks against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rf_we) we_cnt++;
            if (reset) begin
                ph = 0;
            end else begin
                if (ph inside {1, 2, 3}) begin
                    chk("busy_inflight", 32'(busy), 32'(1));
                    chk("ready_inflight", 32'(instr_ready), 32'(0));
                end
                case (ph)
                    1: begin
                        chk("raddr_a", 32'(rf_raddr_a), 32'(cur.rd));
                        chk("raddr_b", 32'(rf_raddr_b), 32'(cur.rs));
                        chk("illegal_read", 32'(illegal), 32'(!cur.legal));
`ifdef ALU_ILLEGAL_TRAP_EN
                        ph = cur.legal ? 2 : 0;
`else
                        ph = 2;
`endif
                    end
                    2: begin
                        if (cur.legal) begin
                            chk("alu_opcode", 32'(alu_opcode), 32'(cur.opc));
                            chk("alu_a", 32'(alu_a), 32'(cur.a));
                            chk("alu_b", 32'(alu_b), 32'(cur.b));
                            chk("alu_cin", 32'(alu_cin), 32'(cur.cin));
                        end
                        chk("illegal_exec", 32'(illegal), 32'(0));
                        ph = 3;
                    end
                    3: begin
                        chk("rf_we", 32'(rf_we), 32'(cur.wr));
                        if (cur.wr) begin
                            chk("rf_waddr", 32'(rf_waddr), 32'(cur.rd));
                            chk("rf_wdata", 32'(rf_wdata), 32'(cur.c));
                        end
                        chk("alu_idle_wb", {8'h00, alu_opcode, alu_a}, 32'(0));
                        ph = 4;
                    end
                    4: begin
                        chk("psr_flags", 32'(psr_flags), 32'(cur.psr_after));
                        chk("ready_after", 32'(instr_ready), 32'(1));
                        chk("rf_we_after", 32'(rf_we), 32'(0));
                        ph = 0;
                    end
                    default: ;
                endcase
                if (ph == 0 && instr_valid && instr_ready) begin
                    chk("accept_expected", 32'(q.size() != 0), 32'(1));
                    if (q.size() != 0) cur = q.pop_front();
                    ph = 1;
                end
            end
        end
    end

    initial begin
        logic [15:0] w;
        int          cnt0;
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0; mpsr = '0;
        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_psr", 32'(psr_flags), 32'(0));
        chk("rst_we_ill", {rf_we, illegal}, 32'(0));
        chk("rst_alu", {8'h00, alu_opcode, alu_a}, 32'(0));

        preload(4'd1, 16'h0003); preload(4'd2, 16'h0005);
        issue(16'h0152, 1); wait_idle();
        chk("add_r1", 32'(rf[1]), 32'h0008);
        chk("add_zc", 32'(psr_flags[4:3]), 32'(0));

        preload(4'd3, 16'hFFFF);
        issue(16'h5301, 1); wait_idle();
        chk("addi_r3", 32'(rf[3]), 32'h0000);
        chk("addi_zc", 32'(psr_flags[4:3]), 32'b11);
        issue(16'h0373, 1); wait_idle();

        preload(4'd4, 16'h0002); preload(4'd5, 16'h0007);
        issue(16'h04B5, 1); wait_idle();
        chk("cmp_r4", 32'(rf[4]), 32'h0002);
        chk("cmp_znl", {psr_flags[4], psr_flags[1:0]}, 32'b011);

        // second instruction held while the first is in flight
        issue(16'h0152, 1); issue(16'h6207, 1); wait_idle();

        for (int n = 0; n < 60; n++) begin
            w = gen();
`ifdef ALU_ILLEGAL_TRAP_EN
            while (!predict(w).legal) w = gen();
`endif
            issue(w, 1);
            if ($urandom_range(0, 2) != 0) wait_idle();
        end
        wait_idle();

        cnt0 = we_cnt;
`ifdef ALU_ILLEGAL_TRAP_EN
        issue(16'hF000, 1);
        repeat (10) @(negedge clk);
        chk("trap_sticky", 32'(illegal), 32'(1));
        chk("trap_ready", 32'(instr_ready), 32'(0));
        chk("trap_busy", 32'(busy), 32'(1));
        chk("trap_no_we", 32'(we_cnt), 32'(cnt0));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; mpsr = '0;
        @(negedge clk);
        chk("trap_clr", {illegal, instr_ready}, 32'b01);
`else
        issue(16'hF000, 1); wait_idle();
        issue(16'h01A2, 1); wait_idle();
        chk("ill_no_we", 32'(we_cnt), 32'(cnt0));
`endif

        // reset while an ADD sits in EXEC
        issue(16'h0152, 0);
        @(posedge clk); #1;
        cnt0 = we_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(instr_ready), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        @(posedge clk); #1 reset = 1'b0; mpsr = '0;
        repeat (6) @(negedge clk);
        chk("abort_no_we", 32'(we_cnt), 32'(cnt0));
        chk("abort_psr", 32'(psr_flags), 32'(0));

        for (int i = 0; i < 16; i++) chk("rf_final", 32'(rf[i]), 32'(mrf[i]));
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
